// File: rtl/hls_kernel_bridge.sv
// -----------------------------------------------------------------------------
// hls_kernel_bridge
//
// Host-side bridge for one HLS image-effects kernel instance. It starts the
// kernel through the ap_ctrl_hs handshake, serves the kernel's frame_in read
// port from an input frame buffer, and captures the kernel's frame_out write
// port into an output frame buffer that the host reads back.
//
// Optional feature macro: BRIDGE_WATCHDOG_EN
//   When defined, a cycle watchdog bounds START+RUN to TIMEOUT_CYC cycles and
//   adds a sticky 'timeout' output. Undefined: the FSM waits on ap_done forever.
//
// Ports:
//   ap_clk, ap_rst_n        clock (rising edge), asynchronous active-low reset
//   run                     host pulse, starts one invocation (needs ap_idle=1)
//   busy                    high from accepted run until frame_done
//   frame_done              one-cycle pulse when an invocation completes
//   frame_count             completed invocations, wraps at 0xFFFF
//   addr_err                sticky, kernel used an address >= DEPTH
//   timeout                 (watchdog build only) sticky watchdog expiry
//   host_wr_*               input-buffer write port, honoured only when idle
//   host_rd_addr/_data      output-buffer read port, 1-cycle latency
//   ap_start/ready/done/idle  kernel ap_ctrl_hs handshake
//   frame_in_pixel_*        kernel read port, 1-cycle latency
//   frame_out_pixel_*       kernel write port
//   out_wr_count            writes captured this invocation (saturating)
// -----------------------------------------------------------------------------
module hls_kernel_bridge #(
  parameter int PIX_W       = 96,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 1024,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              run,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              addr_err,
`ifdef BRIDGE_WATCHDOG_EN
  output logic              timeout,
`endif
  input  logic              host_wr_en,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [PIX_W-1:0]  host_wr_data,
  input  logic [ADDR_W-1:0] host_rd_addr,
  output logic [PIX_W-1:0]  host_rd_data,
  output logic              ap_start,
  input  logic              ap_ready,
  input  logic              ap_done,
  input  logic              ap_idle,
  input  logic [ADDR_W-1:0] frame_in_pixel_address0,
  input  logic              frame_in_pixel_ce0,
  output logic [PIX_W-1:0]  frame_in_pixel_q0,
  input  logic [ADDR_W-1:0] frame_out_pixel_address0,
  input  logic              frame_out_pixel_ce0,
  input  logic              frame_out_pixel_we0,
  input  logic [PIX_W-1:0]  frame_out_pixel_d0,
  output logic [ADDR_W:0]   out_wr_count
);

  // Buffer index width; DEPTH is expected to be at least 2.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);
  // Saturation value of out_wr_count is 2^ADDR_W.
  localparam logic [ADDR_W:0] WR_CNT_SAT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // True when an address falls inside the buffers.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_LIM);
  endfunction

  logic [PIX_W-1:0] in_buf_mem  [DEPTH];
  logic [PIX_W-1:0] out_buf_mem [DEPTH];

  state_t             state_q, state_d;
  logic               ap_start_q, ap_start_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic               addr_err_q, addr_err_d;
  logic [ADDR_W:0]    out_wr_count_q, out_wr_count_d;
  logic [PIX_W-1:0]   q0_q, q0_d;
  logic [PIX_W-1:0]   host_rd_data_q, host_rd_data_d;

  logic               run_accept_s;
  logic               in_rd_ok_s, in_rd_bad_s;
  logic               out_wr_ok_s, out_wr_bad_s;
  logic               host_wr_ok_s;

`ifdef BRIDGE_WATCHDOG_EN
  logic [31:0]        wd_cnt_q, wd_cnt_d;
  logic               timeout_q, timeout_d;
  logic               wd_hit_s;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  // Port qualification: which accesses are legal this cycle.
  always_comb begin
    run_accept_s = (state_q == ST_IDLE) && run && ap_idle;
    in_rd_ok_s   = frame_in_pixel_ce0 && in_range(frame_in_pixel_address0);
    in_rd_bad_s  = frame_in_pixel_ce0 && !in_range(frame_in_pixel_address0);
    out_wr_ok_s  = frame_out_pixel_ce0 && frame_out_pixel_we0 &&
                   in_range(frame_out_pixel_address0);
    out_wr_bad_s = frame_out_pixel_ce0 && frame_out_pixel_we0 &&
                   !in_range(frame_out_pixel_address0);
    // Host writes are locked out while an invocation is in flight.
    host_wr_ok_s = host_wr_en && !busy_q && in_range(host_wr_addr);
  end

  // Handshake FSM next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    ap_start_d = ap_start_q;
`ifdef BRIDGE_WATCHDOG_EN
    wd_hit_s  = (wd_cnt_q == 32'(TIMEOUT_CYC - 1));
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        ap_start_d = 1'b0;
        if (run_accept_s) begin
          state_d    = ST_START;
          ap_start_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        // ap_ready and ap_done may coincide; go straight to DONE then.
        if (ap_ready) begin
          ap_start_d = 1'b0;
          if (ap_done) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          ap_start_d = 1'b1;
          state_d    = ST_START;
        end
      end
      ST_RUN: begin
        ap_start_d = 1'b0;
        if (ap_done) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        ap_start_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: begin
        ap_start_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
`ifdef BRIDGE_WATCHDOG_EN
    if (run_accept_s) begin
      wd_cnt_d  = 32'd0;
      timeout_d = 1'b0;
    end else if ((state_q == ST_START) || (state_q == ST_RUN)) begin
      if (wd_hit_s) begin
        state_d    = ST_DONE;
        ap_start_d = 1'b0;
        timeout_d  = 1'b1;
      end else begin
        wd_cnt_d = wd_cnt_q + 32'd1;
      end
    end else begin
      wd_cnt_d = wd_cnt_q;
    end
`endif
    busy_d       = (state_d != ST_IDLE);
    // DONE is always a single cycle, so entering it marks one completion.
    frame_done_d = (state_d == ST_DONE);
    if (frame_done_d) begin
      frame_count_d = frame_count_q + 16'd1;
    end else begin
      frame_count_d = frame_count_q;
    end
  end

  // Status counters and data-port output registers.
  always_comb begin
    if (run_accept_s) begin
      addr_err_d = in_rd_bad_s || out_wr_bad_s;
    end else begin
      addr_err_d = addr_err_q || in_rd_bad_s || out_wr_bad_s;
    end

    if (run_accept_s) begin
      out_wr_count_d = {(ADDR_W+1){1'b0}};
    end else if (out_wr_ok_s && (out_wr_count_q != WR_CNT_SAT)) begin
      out_wr_count_d = out_wr_count_q + {{ADDR_W{1'b0}}, 1'b1};
    end else begin
      out_wr_count_d = out_wr_count_q;
    end

    if (in_rd_ok_s) begin
      q0_d = in_buf_mem[frame_in_pixel_address0[IDX_W-1:0]];
    end else if (in_rd_bad_s) begin
      q0_d = {PIX_W{1'b0}};
    end else begin
      q0_d = q0_q;
    end

    if (in_range(host_rd_addr)) begin
      host_rd_data_d = out_buf_mem[host_rd_addr[IDX_W-1:0]];
    end else begin
      host_rd_data_d = {PIX_W{1'b0}};
    end
  end

  // Control and status flops with asynchronous reset.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q        <= ST_IDLE;
      ap_start_q     <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_count_q  <= 16'd0;
      addr_err_q     <= 1'b0;
      out_wr_count_q <= {(ADDR_W+1){1'b0}};
      q0_q           <= {PIX_W{1'b0}};
      host_rd_data_q <= {PIX_W{1'b0}};
`ifdef BRIDGE_WATCHDOG_EN
      wd_cnt_q       <= 32'd0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      ap_start_q     <= ap_start_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
      frame_count_q  <= frame_count_d;
      addr_err_q     <= addr_err_d;
      out_wr_count_q <= out_wr_count_d;
      q0_q           <= q0_d;
      host_rd_data_q <= host_rd_data_d;
`ifdef BRIDGE_WATCHDOG_EN
      wd_cnt_q       <= wd_cnt_d;
      timeout_q      <= timeout_d;
`endif
    end
  end

  // Input frame buffer: written by the host only (contents not reset).
  always_ff @(posedge ap_clk) begin
    if (host_wr_ok_s) begin
      in_buf_mem[host_wr_addr[IDX_W-1:0]] <= host_wr_data;
    end
  end

  // Output frame buffer: written by the kernel only (contents not reset).
  always_ff @(posedge ap_clk) begin
    if (out_wr_ok_s) begin
      out_buf_mem[frame_out_pixel_address0[IDX_W-1:0]] <= frame_out_pixel_d0;
    end
  end

  assign ap_start          = ap_start_q;
  assign busy              = busy_q;
  assign frame_done        = frame_done_q;
  assign frame_count       = frame_count_q;
  assign addr_err          = addr_err_q;
  assign out_wr_count      = out_wr_count_q;
  assign frame_in_pixel_q0 = q0_q;
  assign host_rd_data      = host_rd_data_q;
`ifdef BRIDGE_WATCHDOG_EN
  assign timeout           = timeout_q;
`endif

endmodule

// File: tb/tb_hls_kernel_bridge.sv
// -----------------------------------------------------------------------------
// tb_hls_kernel_bridge
//
// Self-checking bench for hls_kernel_bridge. The bench plays both host and
// kernel, driving inputs #1 after the rising edge and sampling there too.
// Read-data predictions go through scoreboard queues; kernel read-port
// vectors are table driven; handshake corner cases are hand sequenced.
// -----------------------------------------------------------------------------
module tb_hls_kernel_bridge;

  localparam int PIX_W  = 96;
  localparam int ADDR_W = 16;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n;
  logic              run;
  logic              busy;
  logic              frame_done;
  logic [15:0]       frame_count;
  logic              addr_err;
`ifdef BRIDGE_WATCHDOG_EN
  logic              timeout;
`endif
  logic              host_wr_en;
  logic [ADDR_W-1:0] host_wr_addr;
  logic [PIX_W-1:0]  host_wr_data;
  logic [ADDR_W-1:0] host_rd_addr;
  logic [PIX_W-1:0]  host_rd_data;
  logic              ap_start;
  logic              ap_ready;
  logic              ap_done;
  logic              ap_idle;
  logic [ADDR_W-1:0] fi_addr;
  logic              fi_ce;
  logic [PIX_W-1:0]  fi_q;
  logic [ADDR_W-1:0] fo_addr;
  logic              fo_ce;
  logic              fo_we;
  logic [PIX_W-1:0]  fo_d;
  logic [ADDR_W:0]   out_wr_count;

  int checks   = 0;
  int failures = 0;

  logic [PIX_W-1:0] q0_sb[$];
  logic [PIX_W-1:0] rd_sb[$];

  typedef struct {
    logic              ce;
    logic [ADDR_W-1:0] addr;
    logic              hwr;
    logic [PIX_W-1:0]  exp_q0;
    logic              exp_err;
  } rd_vec_t;

  rd_vec_t vecs[8];

  hls_kernel_bridge dut (
    .ap_clk                   (ap_clk),
    .ap_rst_n                 (ap_rst_n),
    .run                      (run),
    .busy                     (busy),
    .frame_done               (frame_done),
    .frame_count              (frame_count),
    .addr_err                 (addr_err),
`ifdef BRIDGE_WATCHDOG_EN
    .timeout                  (timeout),
`endif
    .host_wr_en               (host_wr_en),
    .host_wr_addr             (host_wr_addr),
    .host_wr_data             (host_wr_data),
    .host_rd_addr             (host_rd_addr),
    .host_rd_data             (host_rd_data),
    .ap_start                 (ap_start),
    .ap_ready                 (ap_ready),
    .ap_done                  (ap_done),
    .ap_idle                  (ap_idle),
    .frame_in_pixel_address0  (fi_addr),
    .frame_in_pixel_ce0       (fi_ce),
    .frame_in_pixel_q0        (fi_q),
    .frame_out_pixel_address0 (fo_addr),
    .frame_out_pixel_ce0      (fo_ce),
    .frame_out_pixel_we0      (fo_we),
    .frame_out_pixel_d0       (fo_d),
    .out_wr_count             (out_wr_count)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic pop_q0(input string nm);
    if (q0_sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 128'd1, 128'd0);
    end else begin
      chk(nm, {32'd0, fi_q}, {32'd0, q0_sb.pop_front()});
    end
  endtask

  task automatic pop_rd(input string nm);
    if (rd_sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 128'd1, 128'd0);
    end else begin
      chk(nm, {32'd0, host_rd_data}, {32'd0, rd_sb.pop_front()});
    end
  endtask

  initial begin
    logic [ADDR_W-1:0] rd_addrs [6];
    logic [PIX_W-1:0]  rd_exp   [6];

    // kernel read-port vectors, applied while the kernel is running
    vecs[0] = '{1'b1, 16'd2,    1'b0, 96'h3, 1'b0};
    vecs[1] = '{1'b1, 16'd0,    1'b1, 96'h1, 1'b0}; // host write to addr 2 locked out
    vecs[2] = '{1'b1, 16'd2,    1'b0, 96'h3, 1'b0}; // still the original data
    vecs[3] = '{1'b0, 16'd3,    1'b0, 96'h3, 1'b0}; // ce0=0 holds q0
    vecs[4] = '{1'b1, 16'd3,    1'b0, 96'h4, 1'b0};
    vecs[5] = '{1'b1, 16'd1024, 1'b0, 96'h0, 1'b1}; // out of range
    vecs[6] = '{1'b0, 16'd1,    1'b0, 96'h0, 1'b1}; // hold, err sticky
    vecs[7] = '{1'b1, 16'd1,    1'b0, 96'h2, 1'b1};

    rd_addrs[0] = 16'd0;    rd_exp[0] = 96'hAAAA;
    rd_addrs[1] = 16'd5;    rd_exp[1] = 96'hAAAA;
    rd_addrs[2] = 16'd7;    rd_exp[2] = 96'hAAAA;
    rd_addrs[3] = 16'd6;    rd_exp[3] = 96'hAAAA;
    rd_addrs[4] = 16'd1024; rd_exp[4] = 96'h0;
    rd_addrs[5] = 16'd3;    rd_exp[5] = 96'hAAAA;

    ap_rst_n = 1'b0; run = 1'b0;
    host_wr_en = 1'b0; host_wr_addr = 16'd0; host_wr_data = 96'd0;
    host_rd_addr = 16'hFFFF;
    ap_ready = 1'b0; ap_done = 1'b0; ap_idle = 1'b1;
    fi_addr = 16'd0; fi_ce = 1'b0;
    fo_addr = 16'd0; fo_ce = 1'b0; fo_we = 1'b0; fo_d = 96'd0;
    tick(); tick();

    // reset state
    chk("rst_busy",         {127'd0, busy}, 128'd0);
    chk("rst_frame_done",   {127'd0, frame_done}, 128'd0);
    chk("rst_frame_count",  {112'd0, frame_count}, 128'd0);
    chk("rst_addr_err",     {127'd0, addr_err}, 128'd0);
    chk("rst_ap_start",     {127'd0, ap_start}, 128'd0);
    chk("rst_q0",           {32'd0, fi_q}, 128'd0);
    chk("rst_host_rd",      {32'd0, host_rd_data}, 128'd0);
    chk("rst_out_wr_count", {111'd0, out_wr_count}, 128'd0);

    ap_rst_n = 1'b1;
    rd_sb.push_back(96'h0); // host_rd_addr out of range reads zero
    tick();
    pop_rd("idle_rd_oor");

    // load in_buf[0..3] = 1..4
    for (int i = 0; i < 4; i++) begin
      host_wr_en = 1'b1; host_wr_addr = 16'(i); host_wr_data = 96'(i + 1);
      tick();
    end
    host_wr_en = 1'b0;

    // run ignored while the kernel reports not idle
    ap_idle = 1'b0; run = 1'b1;
    tick();
    chk("notidle_busy",  {127'd0, busy}, 128'd0);
    chk("notidle_start", {127'd0, ap_start}, 128'd0);
    run = 1'b0; ap_idle = 1'b1;
    tick();

    // ---- basic run ----
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("run1_busy",  {127'd0, busy}, 128'd1);
    chk("run1_start", {127'd0, ap_start}, 128'd1);
    tick();
    chk("run1_start_held", {127'd0, ap_start}, 128'd1);
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    chk("run1_start_drop", {127'd0, ap_start}, 128'd0);
    chk("run1_busy_run",   {127'd0, busy}, 128'd1);

    // kernel read port vectors
    for (int i = 0; i < 8; i++) begin
      fi_ce = vecs[i].ce; fi_addr = vecs[i].addr;
      host_wr_en = vecs[i].hwr; host_wr_addr = 16'd2; host_wr_data = 96'h99;
      q0_sb.push_back(vecs[i].exp_q0);
      tick();
      pop_q0($sformatf("rdvec%0d_q0", i));
      chk($sformatf("rdvec%0d_err", i), {127'd0, addr_err}, {127'd0, vecs[i].exp_err});
      chk($sformatf("rdvec%0d_done", i), {127'd0, frame_done}, 128'd0);
    end
    fi_ce = 1'b0; host_wr_en = 1'b0;

    // capture: 0xAAAA to addresses 0..7
    for (int i = 0; i < 8; i++) begin
      fo_ce = 1'b1; fo_we = 1'b1; fo_addr = 16'(i); fo_d = 96'hAAAA;
      tick();
      chk($sformatf("wr%0d_count", i), {111'd0, out_wr_count}, 128'(i + 1));
    end
    fo_ce = 1'b1; fo_we = 1'b0; fo_addr = 16'd5; fo_d = 96'h5555;
    tick();
    chk("ce_no_we_count", {111'd0, out_wr_count}, 128'd8);
    fo_ce = 1'b0; fo_we = 1'b1; fo_addr = 16'd6;
    tick();
    chk("we_no_ce_count", {111'd0, out_wr_count}, 128'd8);
    fo_ce = 1'b0; fo_we = 1'b0;

    // host readback works mid-run
    host_rd_addr = 16'd5; rd_sb.push_back(96'hAAAA);
    tick();
    pop_rd("run_rd5");

    // second run while busy is ignored
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("run_busy_ign_start", {127'd0, ap_start}, 128'd0);
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    chk("run1_done_pulse", {127'd0, frame_done}, 128'd1);
    chk("run1_count",      {112'd0, frame_count}, 128'd1);
    chk("run1_busy_done",  {127'd0, busy}, 128'd1);
    tick();
    chk("run1_done_end", {127'd0, frame_done}, 128'd0);
    chk("run1_busy_low", {127'd0, busy}, 128'd0);
    tick(); tick(); tick();
    chk("run1_no_requeue_busy",  {127'd0, busy}, 128'd0);
    chk("run1_no_requeue_count", {112'd0, frame_count}, 128'd1);

    // host readback in idle through the scoreboard
    for (int i = 0; i < 6; i++) begin
      host_rd_addr = rd_addrs[i];
      rd_sb.push_back(rd_exp[i]);
      tick();
      pop_rd($sformatf("idle_rd%0d", i));
    end

    // ---- same-cycle ap_ready + ap_done ----
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("run2_err_clr",   {127'd0, addr_err}, 128'd0);
    chk("run2_count_clr", {111'd0, out_wr_count}, 128'd0);
    chk("run2_start",     {127'd0, ap_start}, 128'd1);
    ap_ready = 1'b1; ap_done = 1'b1;
    tick();
    ap_ready = 1'b0; ap_done = 1'b0;
    chk("run2_done_pulse", {127'd0, frame_done}, 128'd1);
    chk("run2_count",      {112'd0, frame_count}, 128'd2);
    chk("run2_start_drop", {127'd0, ap_start}, 128'd0);
    tick();
    chk("run2_idle", {127'd0, busy}, 128'd0);

    // ---- reset mid-run ----
    run = 1'b1;
    tick();
    run = 1'b0;
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    fo_ce = 1'b1; fo_we = 1'b1; fo_addr = 16'd2000; fo_d = 96'h1;
    tick();
    fo_ce = 1'b0; fo_we = 1'b0;
    chk("run3_wr_oor_err",   {127'd0, addr_err}, 128'd1);
    chk("run3_wr_oor_count", {111'd0, out_wr_count}, 128'd0);
    fi_ce = 1'b1; fi_addr = 16'd3;
    tick();
    fi_ce = 1'b0;
    chk("run3_q0", {32'd0, fi_q}, 128'h4);
    ap_rst_n = 1'b0;
    #1;
    chk("mid_rst_start", {127'd0, ap_start}, 128'd0);
    chk("mid_rst_busy",  {127'd0, busy}, 128'd0);
    chk("mid_rst_count", {112'd0, frame_count}, 128'd0);
    chk("mid_rst_err",   {127'd0, addr_err}, 128'd0);
    chk("mid_rst_q0",    {32'd0, fi_q}, 128'd0);
    tick();
    ap_rst_n = 1'b1;
    tick();
    chk("post_rst_busy", {127'd0, busy}, 128'd0);

    if (q0_sb.size() != 0 || rd_sb.size() != 0) begin
      chk("sb_leftover", 128'd1, 128'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hls_kernel_bridge.md
Name: hls_kernel_bridge

Overview:
- Host-side counterpart of the HLS image-effects kernel: initiates the kernel through its ap_ctrl_hs handshake (ap_start / ap_ready / ap_done / ap_idle).
- Serves the kernel's frame_in pixel read port from an internal input frame buffer.
- Captures the kernel's frame_out pixel write port into an internal output frame buffer.
- Sits between the host/DMA side (buffer load/readback, run/done) and one kernel instance.

Parameters:
- PIX_W, 96, pixel word width (3 x 32-bit channels).
- ADDR_W, 16, kernel address-port width.
- DEPTH, 1024, pixels per buffer (input and output each); DEPTH <= 2^ADDR_W.
- TIMEOUT_CYC, 1000000, watchdog limit in cycles (used only with the optional feature).

Ports:
- ap_clk  in  1  clock, all logic rising-edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- run  in  1  host pulse; starts one kernel invocation.
- busy  out  1  high from accepted run until frame_done.
- frame_done  out  1  one-cycle pulse when the invocation completes.
- frame_count  out  16  completed invocations, wraps 0xFFFF->0.
- addr_err  out  1  sticky; kernel accessed an address >= DEPTH.
- host_wr_en  in  1  input-buffer write strobe.
- host_wr_addr  in  ADDR_W  input-buffer write address.
- host_wr_data  in  PIX_W  input-buffer write data.
- host_rd_addr  in  ADDR_W  output-buffer read address.
- host_rd_data  out  PIX_W  output-buffer read data, 1-cycle latency.
- ap_start  out  1  kernel start.
- ap_ready  in  1  kernel accepted start.
- ap_done  in  1  kernel finished.
- ap_idle  in  1  kernel idle.
- frame_in_pixel_address0  in  ADDR_W  kernel read address.
- frame_in_pixel_ce0  in  1  kernel read enable.
- frame_in_pixel_q0  out  PIX_W  read data, 1-cycle latency.
- frame_out_pixel_address0  in  ADDR_W  kernel write address.
- frame_out_pixel_ce0  in  1  kernel write chip enable.
- frame_out_pixel_we0  in  1  kernel write enable.
- frame_out_pixel_d0  in  PIX_W  kernel write data.
- out_wr_count  out  ADDR_W+1  writes captured this invocation.

Behaviour:
- Reset values: busy=0, frame_done=0, frame_count=0, addr_err=0, ap_start=0, frame_in_pixel_q0=0, host_rd_data=0, out_wr_count=0, FSM=IDLE.
- Buffer contents are not reset.
- FSM states IDLE, START, RUN, DONE.
  - IDLE: on run=1 and ap_idle=1, go to START; clear out_wr_count and addr_err. If ap_idle=0, run is ignored.
  - START: ap_start=1, held until a cycle with ap_ready=1. That cycle: ap_done=1 goes to DONE, otherwise RUN. ap_start drops the cycle after ap_ready is seen.
  - RUN: ap_start=0; on ap_done=1 go to DONE.
  - DONE: frame_done=1 for exactly one cycle, frame_count+=1, then IDLE.
  - busy=1 in START, RUN and DONE.
- run while busy=1 is ignored (not queued).
- Input read port:
  - On frame_in_pixel_ce0=1, next-cycle q0 = in_buf[address0].
  - address0 >= DEPTH: q0=0, addr_err set.
  - ce0=0: q0 holds its previous value.
- Output write port:
  - On ce0=1 and we0=1 with address0 < DEPTH: out_buf[address0]=d0 and out_wr_count+=1, saturating at 2^ADDR_W.
  - address0 >= DEPTH: write dropped, addr_err set.
- Host access:
  - host_wr_en is honoured only while busy=0; dropped while busy=1.
  - host_wr_addr >= DEPTH: dropped silently.
  - host_rd_data = out_buf[host_rd_addr] one cycle later in any state; returns 0 if host_rd_addr >= DEPTH.
- Host write and kernel read at the same input address in the same cycle cannot occur, because host writes are locked out while busy.
- Asserting ap_rst_n low mid-invocation: immediate return to IDLE, ap_start=0, counters cleared. The kernel is reset on the same net.

Optional Feature:
- Macro BRIDGE_WATCHDOG_EN.
- When defined: a cycle counter runs in START and RUN. If it reaches TIMEOUT_CYC, the FSM goes to DONE, ap_start is dropped, and sticky output timeout (1 bit, reset 0, cleared on the next accepted run) is set. frame_count still increments.
- When not defined: no counter and no timeout port; the FSM waits on ap_done indefinitely.

Test Plan:
- Basic run: load in_buf[0..3]=0x1..0x4; pulse run; kernel model asserts ap_ready 2 cycles later and ap_done 10 cycles later -> ap_start high exactly until ap_ready, frame_done one pulse, frame_count=1, busy low the cycle after frame_done.
- Read latency: kernel ce0=1, address0=2 -> q0=0x3 next cycle. address0=1024 -> q0=0, addr_err=1.
- Capture: kernel writes d0=0xAAAA at addresses 0..7 with ce0=we0=1 -> out_wr_count=8; host_rd_addr=5 gives 0xAAAA one cycle later. A ce0=1, we0=0 cycle does not write.
- Same-cycle handshake: ap_ready and ap_done both high in the first START cycle -> DONE next cycle, frame_done pulse, no RUN cycle.
- Lockout/ignore: host_wr_en during RUN leaves in_buf unchanged; a second run during RUN gives frame_count=1 after completion, not 2.
- Reset mid-run: ap_rst_n=0 in RUN -> ap_start=0, busy=0, frame_count=0 immediately. With BRIDGE_WATCHDOG_EN and TIMEOUT_CYC=50, no ap_done -> timeout=1 and frame_done at cycle 50.
